// File: rtl/fmv_pkg.sv
// fmv_pkg
// Shared types and constants for the SRAM read/posted-write arbiter:
//   - SRAM address width and default timing/queue parameters
//   - arbiter state encoding
//   - layout of one posted-write queue entry ({byte address, data byte})
package fmv_pkg;

    localparam int SRAM_AW      = 19;
    localparam int RD_WAIT_DEF  = 2;
    localparam int WQ_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [7:0]         data;
    } wq_entry_t;

    localparam int WQ_ENTRY_W = $bits(wq_entry_t);

endpackage

// File: rtl/srm_wr_fifo.sv
// srm_wr_fifo
// Small synchronous FIFO holding posted MCU writes until the arbiter
// gets the SRAM port. Head entry is visible combinationally on dout so
// the arbiter can latch it on the same edge that pops it.
// Ports:
//   clk, rst_n   clock (state changes on falling edge), sync active-low reset
//   push, din    enqueue request and data (ignored when full without pop)
//   pop          dequeue request (ignored when empty)
//   dout         current head entry
//   count        number of stored entries
//   full, empty  status flags
module srm_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Storage: one register per slot, written only when the write pointer
    // selects it. Pointers wrap naturally because DEPTH is a power of 2.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(negedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi))) begin
                mem_q[gi] <= din;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign dout  = mem_q[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fmv_srm_arb.sv
// fmv_srm_arb
// Arbitrates a single asynchronous 16-bit SRAM between CPU reads and
// byte-wide MCU writes that are posted through a small queue.
// Ports:
//   clk, rst_n                 clock (all state on falling edge), sync active-low reset
//   cpu_req, cpu_addr          level read request and byte address
//   cpu_rdata, cpu_rvalid      read data / valid (valid held until cpu_req drops)
//   pi_we, pi_addr, pi_data    single-cycle MCU write strobe, address, byte
//   wq_full, wq_ovf            queue full, sticky write-dropped flag
//   mem_addr, mem_di, mem_do   SRAM address, write data, read data
//   mem_oe, mem_we_hi/lo       SRAM output enable and byte-lane write strobes
module fmv_srm_arb
    import fmv_pkg::*;
#(
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [18:0] cpu_addr,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        pi_we,
    input  logic [18:0] pi_addr,
    input  logic [7:0]  pi_data,
    output logic        wq_full,
    output logic        wq_ovf,
    output logic [18:0] mem_addr,
    output logic [15:0] mem_di,
    input  logic [15:0] mem_do,
    output logic        mem_oe,
    output logic        mem_we_hi,
    output logic        mem_we_lo
);

    localparam int CW = $clog2(WQ_DEPTH) + 1;

    state_t      state_reg, state_next;
    logic        req_s_reg, req_d_reg;
    logic        pending_reg, pending_next;
    logic        rd_live_reg, rd_live_next;
    logic [2:0]  rd_cnt_reg, rd_cnt_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        rvalid_reg, rvalid_next;
    logic [18:0] addr_reg, addr_next;
    logic [15:0] di_reg, di_next;
    logic        oe_reg, oe_next;
    logic        we_hi_reg, we_hi_next;
    logic        we_lo_reg, we_lo_next;
    logic        ovf_reg, ovf_next;

    wq_entry_t   wq_din, wq_head;
    logic        wq_pop, wq_empty, wq_full_i;
    logic [CW-1:0] wq_count;
    logic        req_rise, rd_go, wr_urgent;

    assign wq_din = '{addr: pi_addr, data: pi_data};

    srm_wr_fifo #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (WQ_ENTRY_W)
    ) u_wq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pi_we),
        .din   (wq_din),
        .pop   (wq_pop),
        .dout  (wq_head),
        .count (wq_count),
        .full  (wq_full_i),
        .empty (wq_empty)
    );

    // cpu_req is registered once, and the rising edge is taken between the
    // registered copy and its delayed copy; this fixes the read latency.
    assign req_rise  = req_s_reg && !req_d_reg;
    // A pending read is only serviced while the request is still asserted.
    assign rd_go     = pending_reg && req_s_reg;
    // A nearly full queue takes the port ahead of reads so it cannot overflow.
    assign wr_urgent = !wq_empty && (wq_count >= CW'(WQ_DEPTH - 1));

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        rd_live_next = rd_live_reg;
        rd_cnt_next  = rd_cnt_reg;
        rdata_next   = rdata_reg;
        rvalid_next  = rvalid_reg && req_s_reg;
        addr_next    = addr_reg;
        di_next      = di_reg;
        oe_next      = 1'b0;
        we_hi_next   = 1'b0;
        we_lo_next   = 1'b0;
        wq_pop       = 1'b0;

        if (!req_s_reg) begin
            pending_next = 1'b0;
        end else if (req_rise) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (wr_urgent || (!rd_go && !wq_empty)) begin
                    wq_pop     = 1'b1;
                    addr_next  = wq_head.addr;
                    di_next    = {wq_head.data, wq_head.data};
                    state_next = ST_WR_SETUP;
                end else if (rd_go) begin
                    addr_next    = cpu_addr;
                    oe_next      = 1'b1;
                    rd_cnt_next  = 3'd0;
                    pending_next = 1'b0;
                    rd_live_next = 1'b1;
                    state_next   = ST_RD;
                end
            end
            ST_RD: begin
                // Dropping cpu_req mid-read lets the access finish silently.
                rd_live_next = rd_live_reg && req_s_reg;
                if (rd_cnt_reg == 3'(RD_WAIT - 1)) begin
                    if (rd_live_reg && req_s_reg) begin
                        rdata_next  = mem_do;
                        rvalid_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else begin
                    oe_next     = 1'b1;
                    rd_cnt_next = rd_cnt_reg + 3'd1;
                end
            end
            ST_WR_SETUP: begin
                we_hi_next = !addr_reg[0];
                we_lo_next = addr_reg[0];
                state_next = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                state_next = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        ovf_next = ovf_reg || (pi_we && wq_full_i && !wq_pop);
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            req_s_reg   <= 1'b0;
            req_d_reg   <= 1'b0;
            pending_reg <= 1'b0;
            rd_live_reg <= 1'b0;
            rd_cnt_reg  <= 3'd0;
            rdata_reg   <= 16'd0;
            rvalid_reg  <= 1'b0;
            addr_reg    <= 19'd0;
            di_reg      <= 16'd0;
            oe_reg      <= 1'b0;
            we_hi_reg   <= 1'b0;
            we_lo_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_s_reg   <= cpu_req;
            req_d_reg   <= req_s_reg;
            pending_reg <= pending_next;
            rd_live_reg <= rd_live_next;
            rd_cnt_reg  <= rd_cnt_next;
            rdata_reg   <= rdata_next;
            rvalid_reg  <= rvalid_next;
            addr_reg    <= addr_next;
            di_reg      <= di_next;
            oe_reg      <= oe_next;
            we_hi_reg   <= we_hi_next;
            we_lo_reg   <= we_lo_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign cpu_rdata  = rdata_reg;
    assign cpu_rvalid = rvalid_reg;
    assign wq_full    = wq_full_i;
    assign wq_ovf     = ovf_reg;
    assign mem_addr   = addr_reg;
    assign mem_di     = di_reg;
    assign mem_oe     = oe_reg;
    assign mem_we_hi  = we_hi_reg;
    assign mem_we_lo  = we_lo_reg;

endmodule
